// File: rtl/cpuif_initiator_if.sv
// rtl/cpuif_initiator_if.sv - command, response and cpu-side bus signals of cpuif_initiator
interface cpuif_initiator_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_is_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wr_data;
  logic [DATA_WIDTH-1:0] cmd_wr_biten;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_is_wr;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  cpu_req;
  logic                  cpu_req_is_wr;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wr_data;
  logic [DATA_WIDTH-1:0] cpu_wr_biten;
  logic                  cpu_req_stall_wr;
  logic                  cpu_req_stall_rd;
  logic                  cpu_rd_ack;
  logic                  cpu_rd_err;
  logic [DATA_WIDTH-1:0] cpu_rd_data;
  logic                  cpu_wr_ack;
  logic                  cpu_wr_err;

  modport master (
    input  cmd_valid, cmd_is_wr, cmd_addr, cmd_wr_data, cmd_wr_biten,
    output cmd_ready,
    output rsp_valid, rsp_is_wr, rsp_data, rsp_err, rsp_timeout,
    input  rsp_ready,
    output cpu_req, cpu_req_is_wr, cpu_addr, cpu_wr_data, cpu_wr_biten,
    input  cpu_req_stall_wr, cpu_req_stall_rd, cpu_rd_ack, cpu_rd_err, cpu_rd_data,
    input  cpu_wr_ack, cpu_wr_err
  );

  modport slave (
    output cmd_valid, cmd_is_wr, cmd_addr, cmd_wr_data, cmd_wr_biten,
    input  cmd_ready,
    input  rsp_valid, rsp_is_wr, rsp_data, rsp_err, rsp_timeout,
    output rsp_ready,
    input  cpu_req, cpu_req_is_wr, cpu_addr, cpu_wr_data, cpu_wr_biten,
    output cpu_req_stall_wr, cpu_req_stall_rd, cpu_rd_ack, cpu_rd_err, cpu_rd_data,
    output cpu_wr_ack, cpu_wr_err
  );
endinterface

// File: rtl/cpuif_initiator.sv
// rtl/cpuif_initiator.sv - single-outstanding cpu_if bus master; CPUIF_TIMEOUT_EN adds a request timeout
module cpuif_initiator #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
`ifdef CPUIF_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input logic          clk,
  input logic          reset,
  cpuif_initiator_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  req_q, req_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] biten_q, biten_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  // Stall/ack are always interpreted against the type of the captured request
  logic stall, ack, done;
  assign stall = is_wr_q ? bus.cpu_req_stall_wr : bus.cpu_req_stall_rd;
  assign ack   = is_wr_q ? bus.cpu_wr_ack : bus.cpu_rd_ack;
  assign done  = ack && ((state_q == REQ && !stall) || state_q == WAIT);

`ifdef CPUIF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_to_q, rsp_to_d;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    req_d       = req_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    biten_d     = biten_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef CPUIF_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_to_d    = rsp_to_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_ready_q && bus.cmd_valid) begin
          is_wr_d     = bus.cmd_is_wr;
          addr_d      = bus.cmd_addr;
          wr_data_d   = bus.cmd_wr_data;
          biten_d     = bus.cmd_wr_biten;
          cmd_ready_d = 1'b0;
          req_d       = 1'b1;
          state_d     = REQ;
`ifdef CPUIF_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      REQ: begin
        if (!stall) begin
          req_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: ;
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A matching ack always beats an expiring timeout in the same cycle
    if (done) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      rsp_data_d  = is_wr_q ? '0 : bus.cpu_rd_data;
      rsp_err_d   = is_wr_q ? bus.cpu_wr_err : bus.cpu_rd_err;
`ifdef CPUIF_TIMEOUT_EN
      rsp_to_d    = 1'b0;
    end else if (state_q == REQ || state_q == WAIT) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d     = RESP;
        req_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b1;
        rsp_to_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      req_q       <= 1'b0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      biten_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef CPUIF_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      req_q       <= req_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      biten_q     <= biten_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef CPUIF_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_to_q    <= rsp_to_d;
`endif
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.cpu_req       = req_q;
  assign bus.cpu_req_is_wr = is_wr_q;
  assign bus.cpu_addr      = addr_q;
  assign bus.cpu_wr_data   = wr_data_q;
  assign bus.cpu_wr_biten  = biten_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_is_wr     = is_wr_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_err       = rsp_err_q;
`ifdef CPUIF_TIMEOUT_EN
  assign bus.rsp_timeout   = rsp_to_q;
`else
  assign bus.rsp_timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_cpuif_initiator.sv
// tb/tb_cpuif_initiator.sv - self-checking bench for cpuif_initiator
module tb_cpuif_initiator;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpuif_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cpuif_initiator #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
`ifdef CPUIF_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        is_wr;
    logic [15:0] addr, wdata, biten, rdata;
    logic        err;
    int          stall, ack_dly, rdy_dly;
    logic        stray;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat, exp_req;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_wait;
  int   lat;
  vec_t vt[5];
  vec_t nx;
  vec_t v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: response contents and timing follow directly from the command and the target's behaviour
  function automatic vec_t model(input vec_t r);
    vec_t m = r;
    m.exp_data = r.is_wr ? 16'h0000 : r.rdata;
    m.exp_err  = r.err;
    m.exp_lat  = 2 + r.stall + r.ack_dly;
    m.exp_req  = r.stall + 1;
    return m;
  endfunction

  task automatic clr_target();
    bus.cpu_req_stall_wr = 1'b0;
    bus.cpu_req_stall_rd = 1'b0;
    bus.cpu_wr_ack       = 1'b0;
    bus.cpu_wr_err       = 1'b0;
    bus.cpu_rd_ack       = 1'b0;
    bus.cpu_rd_err       = 1'b0;
    bus.cpu_rd_data      = '0;
  endtask

  task automatic wait_ready();
    last_wait = 0;
    while (!bus.cmd_ready && last_wait < 20) begin
      @(negedge clk);
      last_wait++;
    end
  endtask

  task automatic run(input vec_t r, input bit hold_next);
    int  req_cnt = 0;
    int  l = 0;
    bit  sm, am;
    bus.cmd_is_wr    = r.is_wr;
    bus.cmd_addr     = r.addr;
    bus.cmd_wr_data  = r.wdata;
    bus.cmd_wr_biten = r.biten;
    bus.cmd_valid    = 1'b1;
    wait_ready();
    if (!bus.cmd_ready) begin
      chk("cmd_accept_bound", 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    for (int c = 1; c <= 60 && l == 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.cmd_valid = 1'b0;
      if (bus.rsp_valid) begin
        l = c;
      end else begin
        if (bus.cpu_req) begin
          req_cnt++;
          chk("cpu_req_is_wr", bus.cpu_req_is_wr, r.is_wr);
          chk("cpu_addr", bus.cpu_addr, r.addr);
          chk("cpu_wr_data", bus.cpu_wr_data, r.wdata);
          chk("cpu_wr_biten", bus.cpu_wr_biten, r.biten);
        end
        sm = (c <= r.stall);
        am = (c == r.stall + 1 + r.ack_dly);
        bus.cpu_req_stall_wr = r.is_wr ? sm : r.stray;
        bus.cpu_req_stall_rd = r.is_wr ? r.stray : sm;
        bus.cpu_wr_ack  = r.is_wr ? am : r.stray;
        bus.cpu_wr_err  = r.is_wr ? (am & r.err) : r.stray;
        bus.cpu_rd_ack  = r.is_wr ? r.stray : am;
        bus.cpu_rd_err  = r.is_wr ? r.stray : (am & r.err);
        bus.cpu_rd_data = (r.is_wr || am) ? r.rdata : 16'hDEAD;
      end
    end
    clr_target();
    chk("rsp_latency", l, r.exp_lat);
    chk("cpu_req_cycles", req_cnt, r.exp_req);
    if (l == 0) return;
    chk("cpu_req_low_in_resp", bus.cpu_req, 0);
    for (int h = 0; h <= r.rdy_dly; h++) begin
      if (hold_next) begin
        bus.cmd_is_wr    = nx.is_wr;
        bus.cmd_addr     = nx.addr;
        bus.cmd_wr_data  = nx.wdata;
        bus.cmd_wr_biten = nx.biten;
        bus.cmd_valid    = 1'b1;
      end
      bus.rsp_ready = (h == r.rdy_dly);
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_is_wr", bus.rsp_is_wr, r.is_wr);
      chk("rsp_data", bus.rsp_data, r.exp_data);
      chk("rsp_err", bus.rsp_err, r.exp_err);
      chk("rsp_timeout", bus.rsp_timeout, 0);
      chk("cmd_ready_in_resp", bus.cmd_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", bus.rsp_valid, 0);
    chk("cmd_ready_after_hs", bus.cmd_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 16'h0010, 16'hA5A5, 16'hFFFF, 16'h0000, 1'b0, 0, 0, 0, 1'b0, 16'h0000, 1'b0, 2, 1};
    vt[1] = '{1'b0, 16'h0004, 16'h0000, 16'h0000, 16'h1234, 1'b0, 3, 2, 0, 1'b0, 16'h1234, 1'b0, 7, 4};
    vt[2] = '{1'b0, 16'h0008, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 0, 2, 1, 1'b1, 16'hFFFF, 1'b1, 4, 1};
    vt[3] = '{1'b1, 16'h0020, 16'h5A5A, 16'h00FF, 16'hBEEF, 1'b1, 2, 1, 0, 1'b1, 16'h0000, 1'b1, 5, 3};
    vt[4] = '{1'b0, 16'hFFFE, 16'h0000, 16'h0000, 16'h8001, 1'b0, 1, 0, 2, 1'b0, 16'h8001, 1'b0, 3, 2};

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_is_wr = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wr_data = '0; bus.cmd_wr_biten = '0; bus.rsp_ready = 1'b0;
    clr_target();
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_cpu_req", bus.cpu_req, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_cpu_addr", bus.cpu_addr, 0);
    reset = 1'b0;
    #1 chk("cmd_ready_before_edge", bus.cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_after_edge", bus.cmd_ready, 1);

    for (int i = 0; i < 5; i++) run(vt[i], 1'b0);

    // Response back-pressure with the next command already waiting
    v = vt[1];
    v.rdy_dly = 5;
    nx = vt[0];
    run(v, 1'b1);
    run(vt[0], 1'b0);
    chk("back_to_back_wait", last_wait, 1);

    for (int i = 0; i < 40; i++) begin
      v.is_wr   = 1'($urandom_range(0, 1));
      v.addr    = 16'($urandom);
      v.wdata   = 16'($urandom);
      v.biten   = 16'($urandom);
      v.rdata   = 16'($urandom);
      v.err     = 1'($urandom_range(0, 1));
      v.stall   = $urandom_range(0, 3);
      v.ack_dly = $urandom_range(0, 3);
      v.rdy_dly = $urandom_range(0, 2);
      v.stray   = 1'($urandom_range(0, 1));
      v = model(v);
      run(v, 1'b0);
      chk("rand_accept_wait", last_wait, 1);
    end

`ifdef CPUIF_TIMEOUT_EN
    bus.cmd_is_wr = 1'b0;
    bus.cmd_addr  = 16'h0100;
    bus.cmd_valid = 1'b1;
    wait_ready();
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.cmd_valid = 1'b0;
      if (bus.rsp_valid) lat = c;
    end
    chk("timeout_latency", lat, TO + 1);
    for (int h = 0; h < 6; h++) begin
      bus.cpu_rd_ack  = (h == 3);
      bus.cpu_rd_data = 16'h7777;
      bus.rsp_ready   = (h == 5);
      chk("to_rsp_valid", bus.rsp_valid, 1);
      chk("to_rsp_err", bus.rsp_err, 1);
      chk("to_rsp_timeout", bus.rsp_timeout, 1);
      chk("to_rsp_data", bus.rsp_data, 0);
      chk("to_cpu_req", bus.cpu_req, 0);
      @(negedge clk);
    end
    clr_target();
    bus.rsp_ready = 1'b0;
    chk("to_rsp_drop", bus.rsp_valid, 0);
`endif

    // Reset while a stalled request is on the bus
    bus.cmd_is_wr = 1'b1;
    bus.cmd_addr  = 16'h0030;
    bus.cmd_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cpu_req_stall_wr = 1'b1;
    chk("req_before_reset", bus.cpu_req, 1);
    reset = 1'b1;
    #1 chk("async_drop_cpu_req", bus.cpu_req, 0);
    @(negedge clk);
    reset = 1'b0;
    clr_target();
    @(negedge clk);

    // Reset while waiting for a read ack; a late ack must not produce a response
    bus.cmd_is_wr = 1'b0;
    bus.cmd_addr  = 16'h0040;
    bus.cmd_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_wait_cpu_req", bus.cpu_req, 0);
    chk("rst_wait_rsp_valid", bus.rsp_valid, 0);
    chk("rst_wait_cmd_ready", bus.cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.cpu_rd_ack  = 1'b1;
    bus.cpu_rd_data = 16'h4444;
    @(negedge clk);
    clr_target();
    for (int i = 0; i < 3; i++) begin
      chk("no_rsp_after_reset", bus.rsp_valid, 0);
      @(negedge clk);
    end
    run(vt[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
